// File: rtl/chip_slot_pkg.sv
// Shared constants and types for the chip-bus slot arbiter.
package chip_slot_pkg;

  // Bit positions of the one-hot class grant.
  localparam int unsigned GNT_REF = 0;
  localparam int unsigned GNT_DSK = 1;
  localparam int unsigned GNT_AUD = 2;
  localparam int unsigned GNT_SPR = 3;
  localparam int unsigned GNT_BPL = 4;
  localparam int unsigned GNT_COP = 5;
  localparam int unsigned GNT_BLT = 6;
  localparam int unsigned GNT_CPU = 7;
  localparam int unsigned NUM_CLASSES = 8;

  // Colour clocks per line.
  localparam int unsigned LINE_SLOTS_PAL  = 227;
  localparam int unsigned LINE_SLOTS_NTSC = 228;

  // Fixed-map boundaries (all fixed slots are odd).
  localparam int unsigned REF_FIRST = 1;
  localparam int unsigned REF_LAST  = 7;
  localparam int unsigned DSK_FIRST = 9;
  localparam int unsigned DSK_LAST  = 13;
  localparam int unsigned AUD_FIRST = 15;
  localparam int unsigned AUD_LAST  = 21;
  localparam int unsigned SPR_FIRST = 23;
  localparam int unsigned SPR_LAST  = 53;

  // Owner of a fixed slot, FIX_NONE for purely dynamic slots.
  typedef enum logic [2:0] {
    FIX_NONE,
    FIX_REF,
    FIX_DSK,
    FIX_AUD,
    FIX_SPR
  } fixed_e;

  // Decoded description of one slot.
  typedef struct packed {
    fixed_e     owner;
    logic [2:0] ch;
    logic       even;
  } slot_info_t;

endpackage

// File: rtl/chip_slot_arbiter_if.sv
// Request/grant bundle between the DMA requesters and the slot arbiter.
interface chip_slot_arbiter_if #(
  parameter int SLOT_W = 8
);
  // Timing inputs from the clock block.
  logic              clk7_en;
  logic              cck;
  logic              line_sync;
  // Requests.
  logic              dsk_req;
  logic [3:0]        aud_req;
  logic [7:0]        spr_req;
  logic              bpl_req;
  logic              cop_req;
  logic              blt_req;
  logic              blt_nasty;
  logic              cpu_req;
  // Registered grant.
  logic [SLOT_W-1:0] slot;
  logic [7:0]        gnt;
  logic [2:0]        gnt_ch;
  logic              slot_strobe;

  modport master (
    output clk7_en, cck, line_sync,
    output dsk_req, aud_req, spr_req, bpl_req, cop_req, blt_req, blt_nasty, cpu_req,
    input  slot, gnt, gnt_ch, slot_strobe
  );

  modport slave (
    input  clk7_en, cck, line_sync,
    input  dsk_req, aud_req, spr_req, bpl_req, cop_req, blt_req, blt_nasty, cpu_req,
    output slot, gnt, gnt_ch, slot_strobe
  );
endinterface

// File: rtl/chip_slot_map.sv
// Combinational decoder: slot number -> fixed owner, channel and parity.
module chip_slot_map
  import chip_slot_pkg::*;
#(
  parameter int SLOT_W = 8
) (
  input  logic [SLOT_W-1:0] slot_n,
  output slot_info_t        info
);

  int unsigned s;

  // Classify the slot against the fixed map; odd slots only carry fixed owners.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    info.owner = FIX_NONE;
    info.ch    = '0;
    info.even  = ~slot_n[0];
    s          = 32'(slot_n);
    if (slot_n[0]) begin
      if (s >= REF_FIRST && s <= REF_LAST) begin
        info.owner = FIX_REF;
        info.ch    = 3'((s - REF_FIRST) >> 1);
      end else if (s >= DSK_FIRST && s <= DSK_LAST) begin
        info.owner = FIX_DSK;
      end else if (s >= AUD_FIRST && s <= AUD_LAST) begin
        info.owner = FIX_AUD;
        info.ch    = 3'((s - AUD_FIRST) >> 1);
      end else if (s >= SPR_FIRST && s <= SPR_LAST) begin
        // Two consecutive odd slots per sprite.
        info.owner = FIX_SPR;
        info.ch    = 3'((s - SPR_FIRST) >> 2);
      end
    end
  end

endmodule

// File: rtl/chip_slot_arbiter.sv
// Per-colour-clock chip-bus slot arbiter: slot counter, fixed map with
// fall-through to dynamic priority arbitration, and CPU anti-starvation.
module chip_slot_arbiter
  import chip_slot_pkg::*;
#(
  parameter int LINE_SLOTS = LINE_SLOTS_PAL,
  parameter int SLOT_W     = 8            // 2**SLOT_W must cover LINE_SLOTS
) (
  input logic                 clk_28,
  input logic                 rst,
  chip_slot_arbiter_if.slave  bus
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LINE_SLOTS - 1);

  logic              stb;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_n;
  logic [7:0]        gnt_q;
  logic [7:0]        gnt_n;
  logic [2:0]        ch_q;
  logic [2:0]        ch_n;
  logic [1:0]        cpu_wait_q;
  logic [1:0]        cpu_wait_n;
  logic              strobe_q;
  logic              fixed_hit;
  logic              starve;
  slot_info_t        info;

  assign stb = bus.clk7_en & bus.cck;

  // Next slot: restart on line_sync or at end of line (never a double wrap).
  assign slot_n = (bus.line_sync || slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);

  chip_slot_map #(.SLOT_W(SLOT_W)) u_map (
    .slot_n (slot_n),
    .info   (info)
  );

  // CPU takes a would-be blitter slot after three consecutive starved slots.
  assign starve = (cpu_wait_q == 2'd3) && !bus.blt_nasty && bus.cpu_req;

  // Arbitrate the upcoming slot and compute the next starvation count.
  always_comb begin
    gnt_n      = '0;
    ch_n       = '0;
    cpu_wait_n = cpu_wait_q;

    unique case (info.owner)
      FIX_REF: fixed_hit = 1'b1;
      FIX_DSK: fixed_hit = bus.dsk_req;
      FIX_AUD: fixed_hit = bus.aud_req[info.ch[1:0]];
      FIX_SPR: fixed_hit = bus.spr_req[info.ch];
      default: fixed_hit = 1'b0;
    endcase

    if (fixed_hit) begin
      ch_n = info.ch;
      unique case (info.owner)
        FIX_REF: gnt_n[GNT_REF] = 1'b1;
        FIX_DSK: gnt_n[GNT_DSK] = 1'b1;
        FIX_AUD: gnt_n[GNT_AUD] = 1'b1;
        default: gnt_n[GNT_SPR] = 1'b1;
      endcase
    end else if (bus.bpl_req) begin
      gnt_n[GNT_BPL] = 1'b1;
    end else if (bus.cop_req && info.even) begin
      gnt_n[GNT_COP] = 1'b1;
    end else if (bus.blt_req) begin
      if (starve) gnt_n[GNT_CPU] = 1'b1;
      else        gnt_n[GNT_BLT] = 1'b1;
    end else if (bus.cpu_req) begin
      gnt_n[GNT_CPU] = 1'b1;
    end

    if (gnt_n[GNT_CPU]) begin
      cpu_wait_n = 2'd0;
    end else if (gnt_n[GNT_BLT] && bus.cpu_req && cpu_wait_q != 2'd3) begin
      cpu_wait_n = cpu_wait_q + 2'd1;
    end
  end

  // Slot registers: advance only on the strobe; reset overrides the strobe.
  always_ff @(posedge clk_28) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      slot_q     <= LAST_SLOT;
      gnt_q      <= '0;
      ch_q       <= '0;
      cpu_wait_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= stb;
      if (stb) begin
        slot_q     <= slot_n;
        gnt_q      <= gnt_n;
        ch_q       <= ch_n;
        cpu_wait_q <= cpu_wait_n;
      end
    end
  end

  assign bus.slot        = slot_q;
  assign bus.gnt         = gnt_q;
  assign bus.gnt_ch      = ch_q;
  assign bus.slot_strobe = strobe_q;

endmodule

// File: tb/tb_chip_slot_arbiter.sv
// Scoreboard bench for chip_slot_arbiter: a reference model predicts each
// slot's grant when the strobe is driven; the DUT output is compared after.
module tb_chip_slot_arbiter;
  import chip_slot_pkg::*;

  localparam int LS = 227;

  typedef struct packed {
    logic       dsk;
    logic [3:0] aud;
    logic [7:0] spr;
    logic       bpl;
    logic       cop;
    logic       blt;
    logic       nasty;
    logic       cpu;
  } req_t;

  typedef struct {
    int         slot;
    logic [7:0] gnt;
    logic [2:0] ch;
  } exp_t;

  logic clk_28 = 1'b0;
  logic rst;
  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_slot;
  int   m_wait;

  chip_slot_arbiter_if #(.SLOT_W(8)) bus ();

  chip_slot_arbiter #(.LINE_SLOTS(LS), .SLOT_W(8)) dut (
    .clk_28 (clk_28),
    .rst    (rst),
    .bus    (bus)
  );

  initial forever #5 clk_28 = ~clk_28;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input req_t r);
    bus.dsk_req   = r.dsk;
    bus.aud_req   = r.aud;
    bus.spr_req   = r.spr;
    bus.bpl_req   = r.bpl;
    bus.cop_req   = r.cop;
    bus.blt_req   = r.blt;
    bus.blt_nasty = r.nasty;
    bus.cpu_req   = r.cpu;
  endtask

  function automatic req_t rand_req();
    return req_t'(18'($urandom));
  endfunction

  // Reference model: predict the grant for the slot that this strobe starts.
  function automatic void model_push(input req_t r, input logic sync);
    exp_t e;
    int   sn;
    int   cls;
    int   ch;
    sn  = (sync || m_slot == LS - 1) ? 0 : m_slot + 1;
    cls = -1;
    ch  = 0;
    if (sn % 2 == 1) begin
      if (sn <= 7) begin
        cls = 0; ch = (sn - 1) / 2;
      end else if (sn >= 9 && sn <= 13) begin
        if (r.dsk) cls = 1;
      end else if (sn >= 15 && sn <= 21) begin
        if (r.aud[(sn - 15) / 2]) begin cls = 2; ch = (sn - 15) / 2; end
      end else if (sn >= 23 && sn <= 53) begin
        if (r.spr[(sn - 23) / 4]) begin cls = 3; ch = (sn - 23) / 4; end
      end
    end
    if (cls < 0) begin
      if (r.bpl)                     cls = 4;
      else if (r.cop && sn % 2 == 0) cls = 5;
      else if (r.blt)                cls = (m_wait == 3 && !r.nasty && r.cpu) ? 7 : 6;
      else if (r.cpu)                cls = 7;
    end
    if (cls == 7)                           m_wait = 0;
    else if (cls == 6 && r.cpu && m_wait < 3) m_wait++;
    e.slot = sn;
    e.gnt  = '0;
    if (cls >= 0) e.gnt[cls] = 1'b1;
    e.ch   = 3'(ch);
    m_slot = sn;
    sb_q.push_back(e);
  endfunction

  // One full slot: strobe cycle with the given requests, then seven cycles
  // of random noise on requests/line_sync that must not be sampled.
  task automatic run_slot(input req_t r, input logic sync);
    exp_t e;
    @(negedge clk_28);
    bus.clk7_en   = 1'b1;
    bus.cck       = 1'b1;
    bus.line_sync = sync;
    drive(r);
    model_push(r, sync);
    @(posedge clk_28);
    #1;
    e = sb_q.pop_front();
    check($sformatf("slot@%0d", e.slot), 32'(bus.slot), 32'(e.slot));
    check($sformatf("gnt@%0d", e.slot), 32'(bus.gnt), 32'(e.gnt));
    check($sformatf("gnt_ch@%0d", e.slot), 32'(bus.gnt_ch), 32'(e.ch));
    check("strobe_hi", 32'(bus.slot_strobe), 32'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk_28);
      bus.clk7_en   = (i == 4);
      bus.cck       = (i < 4);
      bus.line_sync = 1'($urandom_range(0, 1));
      drive(rand_req());
      @(posedge clk_28);
      #1;
      if (i == 1) check("strobe_lo", 32'(bus.slot_strobe), 32'd0);
      if (i == 7) begin
        check($sformatf("gnt_hold@%0d", e.slot), 32'(bus.gnt), 32'(e.gnt));
        check($sformatf("slot_hold@%0d", e.slot), 32'(bus.slot), 32'(e.slot));
      end
    end
  endtask

  initial begin
    req_t r;
    exp_t e;
    rst = 1'b1;
    bus.clk7_en = 1'b0;
    bus.cck = 1'b0;
    bus.line_sync = 1'b0;
    drive('0);
    m_slot = LS - 1;
    m_wait = 0;

    // Reset state.
    repeat (3) @(negedge clk_28);
    @(posedge clk_28);
    #1;
    check("rst_slot", 32'(bus.slot), 32'(LS - 1));
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_gnt_ch", 32'(bus.gnt_ch), 32'd0);
    check("rst_strobe", 32'(bus.slot_strobe), 32'd0);
    @(negedge clk_28);
    rst = 1'b0;

    // Idle line with wrap: refresh only.
    repeat (230) run_slot('0, 1'b0);

    // Fixed-slot requests: disk, audio ch2, sprite 7.
    r = '0; r.dsk = 1'b1; r.aud = 4'b0100; r.spr = 8'h80;
    repeat (60) run_slot(r, 1'b0);

    // Copper on even, CPU on odd dynamic slots; then bitplanes take all.
    r = '0; r.cop = 1'b1; r.cpu = 1'b1;
    repeat (30) run_slot(r, 1'b0);
    r.bpl = 1'b1;
    repeat (10) run_slot(r, 1'b0);

    // Blitter vs CPU anti-starvation, then blitter-nasty.
    r = '0; r.blt = 1'b1; r.cpu = 1'b1;
    repeat (16) run_slot(r, 1'b0);
    r.nasty = 1'b1;
    repeat (8) run_slot(r, 1'b0);

    // line_sync at the last slot, then at slot 0.
    while (m_slot != LS - 1) run_slot(rand_req(), 1'b0);
    run_slot(rand_req(), 1'b1);
    run_slot(rand_req(), 1'b1);

    // line_sync at slot 100.
    while (m_slot != 100) run_slot(rand_req(), 1'b0);
    run_slot('0, 1'b1);
    run_slot('0, 1'b0);
    run_slot('0, 1'b0);

    // Reset three cycles into a CPU slot, held across a strobe.
    while (m_slot < 60) run_slot(rand_req(), 1'b0);
    r = '0; r.cpu = 1'b1;
    @(negedge clk_28);
    bus.clk7_en = 1'b1; bus.cck = 1'b1; bus.line_sync = 1'b0;
    drive(r);
    model_push(r, 1'b0);
    @(posedge clk_28);
    #1;
    e = sb_q.pop_front();
    check("cpu_slot_gnt", 32'(bus.gnt), 32'(e.gnt));
    @(negedge clk_28);
    bus.clk7_en = 1'b0;
    @(negedge clk_28);
    @(negedge clk_28);
    rst = 1'b1;
    @(posedge clk_28);
    #1;
    check("midrst_gnt", 32'(bus.gnt), 32'd0);
    check("midrst_slot", 32'(bus.slot), 32'(LS - 1));
    @(negedge clk_28);
    bus.clk7_en = 1'b1; bus.cck = 1'b1;
    @(posedge clk_28);
    #1;
    check("rst_stb_slot", 32'(bus.slot), 32'(LS - 1));
    check("rst_stb_gnt", 32'(bus.gnt), 32'd0);
    check("rst_stb_strobe", 32'(bus.slot_strobe), 32'd0);
    @(negedge clk_28);
    rst = 1'b0;
    bus.clk7_en = 1'b0;
    m_slot = LS - 1;
    m_wait = 0;
    repeat (70) run_slot(rand_req(), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip_slot_arbiter.md
# chip_slot_arbiter

- Per-colour-clock chip-bus slot arbiter for the chipset; runs in the 28 MHz domain.
- Steps through the slots of each video line, one slot per colour-clock period (8 `clk_28` cycles), driven by the `clk7_en`/`cck` outputs of the clock block.
- Each slot is awarded to exactly one requester class: fixed slots for refresh, disk, audio and sprite; dynamic slots shared by bitplane, copper, blitter and CPU.
- The registered grant feeds the chip-RAM address mux and the CPU bus-wait logic.

## Interface
Parameters:
- `LINE_SLOTS`, 227, colour clocks per line (PAL); 228 for NTSC long lines.
- `SLOT_W`, 8, slot counter width; must satisfy 2^SLOT_W ≥ LINE_SLOTS.

Ports:
- `clk_28` in 1: 28 MHz system clock, the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `clk7_en` in 1: 7 MHz clock enable.
- `cck` in 1: colour clock level.
- `line_sync` in 1: next slot becomes slot 0 (horizontal restart).
- `dsk_req` in 1: disk DMA request.
- `aud_req` in 4: audio channel 0..3 requests.
- `spr_req` in 8: sprite 0..7 requests.
- `bpl_req` in 1: bitplane fetch request.
- `cop_req` in 1: copper request.
- `blt_req` in 1: blitter request.
- `blt_nasty` in 1: blitter-nasty; disables CPU anti-starvation.
- `cpu_req` in 1: CPU chip-bus request.
- `slot` out SLOT_W: number of the slot currently granted.
- `gnt` out 8: one-hot class grant, all-zero means idle. Bits: 0 REF, 1 DSK, 2 AUD, 3 SPR, 4 BPL, 5 COP, 6 BLT, 7 CPU.
- `gnt_ch` out 3: channel index within the granted class (audio 0..3, sprite 0..7, refresh 0..3); 0 otherwise.
- `slot_strobe` out 1: single-cycle pulse marking the start of a slot.

## Operation
- Slot strobe `stb = clk7_en & cck`; one `stb` every 8 `clk_28` cycles.
- Next slot number, computed on `stb`: `slot_n = (line_sync | slot==LINE_SLOTS-1) ? 0 : slot+1`.
- Fixed map, evaluated on `slot_n`:
  - Odd slots 1, 3, 5, 7: REF, unconditional; `gnt_ch = (slot_n-1)>>1`.
  - Odd slots 9, 11, 13: DSK if `dsk_req`.
  - Odd slots 15..21: AUD ch `(slot_n-15)>>1` if the matching `aud_req` bit is set.
  - Odd slots 23..53: SPR ch `(slot_n-23)>>2` if the matching `spr_req` bit is set.
- A fixed slot whose owner is not requesting falls through to dynamic arbitration.
- All other slots are dynamic, priority order:
  1. BPL.
  2. COP (even slots only).
  3. BLT.
  4. CPU.
- CPU anti-starvation:
  - 2-bit saturating counter `cpu_wait` increments when a slot goes to BLT while `cpu_req=1`.
  - When `cpu_wait==3` and `blt_nasty==0`, a dynamic slot that would go to BLT goes to CPU instead.
  - `cpu_wait` clears on any CPU grant.
  - BPL and COP are never pre-empted by the CPU.
- No request for a slot: `gnt=0`, `gnt_ch=0`.

## Timing
- Requests and `line_sync` are sampled only in the `stb` cycle; requests asserted or dropped elsewhere have no effect.
- `slot`, `gnt`, `gnt_ch` and `cpu_wait` update on the clock edge that samples `stb`. Their values are visible from the next cycle and held stable for 8 cycles, until the following `stb` edge.
- `slot_strobe` is `stb` registered: high for 1 cycle, aligned with the first cycle of the new grant.
- Reset values:
  - `slot = LINE_SLOTS-1`, so the first `stb` after reset produces slot 0.
  - `gnt = 0`, `gnt_ch = 0`, `slot_strobe = 0`, `cpu_wait = 0`.
- `rst` mid-slot: the grant drops to 0 on the next edge; the resumed sequence starts at slot 0.
- `rst` together with `stb`: reset wins.
- `line_sync` at slot LINE_SLOTS-1: next slot is 0 (no double wrap).
- `line_sync` at slot 0: slot 0 repeats.
- Wrap: LINE_SLOTS-1 → 0 with no gap strobe.

## Structure
- Package `chip_slot_pkg`:
  - Class bit positions (`GNT_REF` .. `GNT_CPU`).
  - Fixed-map boundary constants: 1, 7, 9, 13, 15, 21, 23, 53.
  - Default LINE_SLOTS values for PAL and NTSC.
- Sub-module `chip_slot_map`: purely combinational `slot_n` → {fixed class, channel, even flag} decoder.
- Top level holds the slot counter, the arbitration registers and `cpu_wait`.

## Test plan
- Reset release, no requests, 230 strobes:
  - `slot` runs 0..226 then 0.
  - `gnt` = REF with `gnt_ch` 0..3 at slots 1/3/5/7; 0 elsewhere.
- `aud_req=4'b0100`, `spr_req=8'h80`:
  - AUD `gnt_ch=2` at slot 19.
  - SPR `gnt_ch=7` at slots 51 and 53.
  - Slots 15/17/21 are idle.
- `cop_req` and `cpu_req` held:
  - COP on even dynamic slots, CPU on odd dynamic slots.
  - Adding `bpl_req` yields BPL on every dynamic slot.
- `blt_req` and `cpu_req` held, `blt_nasty=0`, dynamic region:
  - Pattern BLT, BLT, BLT, CPU repeating.
  - With `blt_nasty=1`: BLT only.
- `line_sync` pulsed in the `stb` cycle at slot 100: next `slot=0`, REF at slot 1.
- `rst` asserted 3 cycles into a CPU slot:
  - `gnt=0` on the next edge and `slot=226` during reset.
  - First post-reset strobe gives slot 0.
